fp_int_result_queue: RTL and testbench



---
 rtl/fp_int_result_queue_pkg.sv | 21 ++
 rtl/fp_fflags_accum.sv | 29 ++
 rtl/fp_int_result_queue.sv | 135 +++++++++++++
 tb/tb_fp_int_result_queue.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_int_result_queue_pkg.sv
// Shared FPU definitions for the FP-to-integer result path.
//   FFLAG_*          : bit positions inside the 5-bit fflags vector {NV,DZ,OF,UF,NX}
//   fflags_t         : 5-bit exception flag vector
//   fp_int_entry_t   : one queued FP-to-int result {result, rd, flags}
package fp_int_result_queue_pkg;

  localparam int unsigned FFLAG_NV = 4;
  localparam int unsigned FFLAG_DZ = 3;
  localparam int unsigned FFLAG_OF = 2;
  localparam int unsigned FFLAG_UF = 1;
  localparam int unsigned FFLAG_NX = 0;

  typedef logic [4:0] fflags_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    fflags_t     flags;
  } fp_int_entry_t;

endpackage

// File: rtl/fp_fflags_accum.sv
// Sticky floating-point exception flag register.
//   clk, reset     : clock, synchronous active-high reset (clears flags)
//   csr_we/wdata   : CSR write to fflags
//   accrue_en      : an entry retires this cycle
//   accrue_flags   : flags of the retiring entry
//   fflags         : accrued flags
// The accrued flags are ORed on top of the CSR write so a retiring flag is
// never overwritten by a same-cycle CSR write.
module fp_fflags_accum
  import fp_int_result_queue_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    csr_we,
  input  fflags_t csr_wdata,
  input  logic    accrue_en,
  input  fflags_t accrue_flags,
  output fflags_t fflags
);

  always_ff @(posedge clk) begin
    if (reset) begin
      fflags <= '0;
    end else begin
      fflags <= (csr_we ? csr_wdata : fflags) | (accrue_en ? accrue_flags : '0);
    end
  end

endmodule

// File: rtl/fp_int_result_queue.sv
// In-order result queue between FP-to-integer producers and the integer
// writeback port, with sticky fflags accrual and a pending-rd hazard query.
//   clk, reset                 : clock, synchronous active-high reset
//   in_valid/in_ready          : producer handshake (in_ready = !full)
//   in_result/in_rd/in_flags   : result, destination, exception flags
//   out_valid/out_ready        : writeback handshake
//   out_result/out_rd          : head entry (0 while empty)
//   flush                      : discard all queued entries
//   query_rd/query_hit         : does any valid entry target query_rd (x0 never hits)
//   csr_fflags_we/wdata        : CSR write to fflags
//   fflags                     : accrued exception flags
// Optional build macro FP_RESULT_BYPASS_EN: when the queue is empty, the input
// is presented combinationally on the output and may retire with zero latency.
module fp_int_result_queue
  import fp_int_result_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_result,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_flags,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  input  logic            flush,
  input  logic [4:0]      query_rd,
  output logic            query_hit,
  input  logic            csr_fflags_we,
  input  logic [4:0]      csr_fflags_wdata,
  output logic [4:0]      fflags
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [XLEN-1:0] mem_result [DEPTH];
  logic [4:0]      mem_rd     [DEPTH];
  fflags_t         mem_flags  [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic    empty;
  logic    full;
  logic    retire;
  logic    push;
  logic    pop;
  fflags_t head_flags;
  logic [PW-1:0] q_off;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign in_ready = !full;

  always_comb begin
    out_valid  = !empty;
    out_result = empty ? '0 : mem_result[rd_ptr];
    out_rd     = empty ? '0 : mem_rd[rd_ptr];
    head_flags = mem_flags[rd_ptr];
`ifdef FP_RESULT_BYPASS_EN
    if (empty && in_valid) begin
      out_valid  = 1'b1;
      out_result = in_result;
      out_rd     = in_rd;
      head_flags = in_flags;
    end
`endif
  end

  assign retire = out_valid && out_ready && !flush;

`ifdef FP_RESULT_BYPASS_EN
  // A bypassed result that retires in the same cycle never touches storage.
  assign push = in_valid && in_ready && !flush && !(empty && out_ready);
  assign pop  = retire && !empty;
`else
  assign push = in_valid && in_ready && !flush;
  assign pop  = retire;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= in_result;
      mem_rd[wr_ptr]     <= in_rd;
      mem_flags[wr_ptr]  <= in_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Slot i is live when its distance from the head is below count.
  always_comb begin
    query_hit = 1'b0;
    q_off     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      q_off = PW'(i) - rd_ptr;
      if (({1'b0, q_off} < count) && (mem_rd[i] == query_rd)) query_hit = 1'b1;
    end
`ifdef FP_RESULT_BYPASS_EN
    if (in_valid && (in_rd == query_rd)) query_hit = 1'b1;
`endif
    if (query_rd == '0) query_hit = 1'b0;
  end

  fp_fflags_accum u_fflags (
    .clk          (clk),
    .reset        (reset),
    .csr_we       (csr_fflags_we),
    .csr_wdata    (csr_fflags_wdata),
    .accrue_en    (retire),
    .accrue_flags (head_flags),
    .fflags       (fflags)
  );

endmodule

// File: tb/tb_fp_int_result_queue.sv
module tb_fp_int_result_queue;
  import fp_int_result_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_result;
  logic [4:0]      in_rd;
  logic [4:0]      in_flags;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [4:0]      out_rd;
  logic            flush;
  logic [4:0]      query_rd;
  logic            query_hit;
  logic            csr_fflags_we;
  logic [4:0]      csr_fflags_wdata;
  logic [4:0]      fflags;

  fp_int_result_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_result        (in_result),
    .in_rd            (in_rd),
    .in_flags         (in_flags),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_rd           (out_rd),
    .flush            (flush),
    .query_rd         (query_rd),
    .query_hit        (query_hit),
    .csr_fflags_we    (csr_fflags_we),
    .csr_fflags_wdata (csr_fflags_wdata),
    .fflags           (fflags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total   = 0;
  int bad     = 0;
  int retired = 0;

  logic [XLEN+4:0] sb[$];
  logic [XLEN+4:0] exp_e;

  fflags_t fl_nv, fl_of, fl_uf, fl_nx;

  // Scoreboard: expected {result, rd} pushed on accept, popped on retire.
  always @(negedge clk) begin
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) sb.push_back({in_result, in_rd});
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_retire got=%0h/%0d want=none", out_result, out_rd);
        end else begin
          exp_e = sb.pop_front();
          if ({out_result, out_rd} !== exp_e) begin
            bad++;
            $display("FAIL sb_order got=%0h/%0d want=%0h/%0d",
                     out_result, out_rd, exp_e[XLEN+4:5], exp_e[4:0]);
          end
        end
        retired++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 20 && out_valid; n++) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    query_rd = 5'd5;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b want=1", in_ready); end
    total++; if (fflags !== 5'b0) begin bad++; $display("FAIL rst_fflags got=%0b want=0", fflags); end
    total++; if (query_hit !== 1'b0) begin bad++; $display("FAIL rst_query_hit got=%0b want=0", query_hit); end
    total++; if (out_result !== '0 || out_rd !== 5'd0) begin
      bad++; $display("FAIL rst_out_data got=%0h/%0d want=0/0", out_result, out_rd);
    end
  endtask

  task automatic test_fill_drain();
    int r0;
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_rd = 5'(k); in_result = XLEN'(k % 2); in_flags = '0;
      tick();
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%0b want=0", in_ready); end
    in_rd = 5'd5; in_result = 1;
    for (int k = 0; k < 3; k++) tick();
    total++; if (in_ready !== 1'b0 || out_rd !== 5'd1) begin
      bad++; $display("FAIL full_hold got=%0b/%0d want=0/1", in_ready, out_rd);
    end
    in_valid = 1'b0;
    r0 = retired;
    drain();
    total++; if (retired - r0 !== 4 || out_valid !== 1'b0) begin
      bad++; $display("FAIL drain_count got=%0d want=4", retired - r0);
    end
  endtask

  task automatic test_stream();
    int r0;
    r0 = retired;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_rd = 5'(10 + k); in_result = 32'hA0 + k; in_flags = '0;
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_rd = 5'($urandom_range(1, 31)); in_result = $urandom;
      tick();
      total++; if (dut.count !== 3'd2 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
        bad++; $display("FAIL stream_count cyc=%0d got=%0d want=2", k, dut.count);
      end
    end
    in_valid = 1'b0;
    drain();
    total++; if (retired - r0 !== 22) begin
      bad++; $display("FAIL stream_retired got=%0d want=22", retired - r0);
    end
  endtask

  task automatic test_flags();
    reset = 1'b1; tick(); reset = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_rd = 5'd2; in_result = 1; in_flags = fl_nv; tick();
    in_rd = 5'd3; in_flags = fl_nx; tick();
    in_valid = 1'b0; in_flags = '0;
    out_ready = 1'b1; tick(); tick(); out_ready = 1'b0;
    total++; if (fflags !== 5'b10001) begin bad++; $display("FAIL accrue got=%0b want=10001", fflags); end
    in_valid = 1'b1; in_rd = 5'd4; in_flags = fl_nv; tick();
    in_valid = 1'b0; in_flags = '0;
    out_ready = 1'b1; csr_fflags_we = 1'b1; csr_fflags_wdata = fl_of;
    tick();
    csr_fflags_we = 1'b0; out_ready = 1'b0;
    total++; if (fflags !== 5'b10100) begin bad++; $display("FAIL csr_merge got=%0b want=10100", fflags); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_rd = 5'(3 + k); in_result = 32'h30 + k; in_flags = 5'b11111;
      tick();
    end
    in_rd = 5'd6; out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_flags = '0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%0b want=1", in_ready); end
    total++; if (fflags !== 5'b10100) begin bad++; $display("FAIL flush_fflags got=%0b want=10100", fflags); end
    for (int q = 0; q < 32; q++) begin
      query_rd = 5'(q);
      #0.1;
      total++; if (query_hit !== 1'b0) begin bad++; $display("FAIL flush_query rd=%0d got=%0b want=0", q, query_hit); end
    end
  endtask

  task automatic test_hazard();
    out_ready = 1'b0;
    in_valid = 1'b1; in_rd = 5'd7; in_result = 1; tick();
    in_rd = 5'd0; in_result = 0; tick();
    in_valid = 1'b0;
    query_rd = 5'd7; #1;
    total++; if (query_hit !== 1'b1) begin bad++; $display("FAIL hazard_hit7 got=%0b want=1", query_hit); end
    query_rd = 5'd0; #1;
    total++; if (query_hit !== 1'b0) begin bad++; $display("FAIL hazard_x0 got=%0b want=0", query_hit); end
    query_rd = 5'd7;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    #1;
    total++; if (query_hit !== 1'b0) begin bad++; $display("FAIL hazard_retired got=%0b want=0", query_hit); end
    drain();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hazard_drain got=%0b want=0", out_valid); end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_rd = 5'(20 + k); in_result = 32'h200 + k; in_flags = '0;
      csr_fflags_we = (k == 0); csr_fflags_wdata = 5'b11111;
      tick();
    end
    in_valid = 1'b0; csr_fflags_we = 1'b0;
    total++; if (fflags !== 5'b11111 || in_ready !== 1'b0) begin
      bad++; $display("FAIL prereset_state got=%0b/%0b want=11111/0", fflags, in_ready);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if (dut.count !== 3'd0) begin bad++; $display("FAIL rstfull_count got=%0d want=0", dut.count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstfull_out_valid got=%0b want=0", out_valid); end
    total++; if (fflags !== 5'b0) begin bad++; $display("FAIL rstfull_fflags got=%0b want=0", fflags); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstfull_in_ready got=%0b want=1", in_ready); end
  endtask

  task automatic test_bypass();
    in_valid = 1'b1; out_ready = 1'b1; in_rd = 5'd9; in_result = 32'h55; in_flags = fl_uf;
    #1;
`ifdef FP_RESULT_BYPASS_EN
    total++; if (out_valid !== 1'b1 || out_rd !== 5'd9 || out_result !== 32'h55) begin
      bad++; $display("FAIL bypass_comb got=%0b/%0d/%0h want=1/9/55", out_valid, out_rd, out_result);
    end
    tick();
    in_valid = 1'b0; out_ready = 1'b0; in_flags = '0;
    total++; if (dut.count !== 3'd0) begin bad++; $display("FAIL bypass_count got=%0d want=0", dut.count); end
`else
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL nobypass_comb got=%0b want=0", out_valid); end
    tick();
    in_valid = 1'b0; in_flags = '0;
    total++; if (out_valid !== 1'b1 || out_rd !== 5'd9) begin
      bad++; $display("FAIL nobypass_latency got=%0b/%0d want=1/9", out_valid, out_rd);
    end
    tick();
    out_ready = 1'b0;
`endif
    total++; if (fflags !== 5'b00010 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bypass_fflags got=%0b/%0b want=00010/0", fflags, out_valid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    fl_nv = fflags_t'(1) << FFLAG_NV;
    fl_of = fflags_t'(1) << FFLAG_OF;
    fl_uf = fflags_t'(1) << FFLAG_UF;
    fl_nx = fflags_t'(1) << FFLAG_NX;
    reset = 1'b1; in_valid = 1'b0; in_result = '0; in_rd = '0; in_flags = '0;
    out_ready = 1'b0; flush = 1'b0; query_rd = '0;
    csr_fflags_we = 1'b0; csr_fflags_wdata = '0;
    test_reset();
    test_fill_drain();
    test_stream();
    test_flags();
    test_flush();
    test_hazard();
    test_reset_full();
    test_bypass();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
